// File: rtl/decode_stage.sv
// Single-issue decode stage: splits a 16-bit instruction into fields, flags immediate
// forms and undefined opcodes, and buffers through an output register plus one skid entry.
module decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [15:0] in_instr,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_opcode,
    output logic [3:0]  out_rd,
    output logic [3:0]  out_rs,
    output logic [3:0]  out_rt,
    output logic [7:0]  out_imm8,
    output logic        out_extend,
    output logic        out_uses_imm,
    output logic        out_illegal,
    output logic        halted
);

    localparam int unsigned INSTR_W = 16;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic               uses_imm;
        logic               extend;
        logic               illegal;
    } entry_t;

    // Opcode classification into immediate-use, sign-extend and illegal flags
    function automatic entry_t decode(input logic [INSTR_W-1:0] instr);
        entry_t e;
        e.instr    = instr;
        e.uses_imm = 1'b0;
        e.extend   = 1'b0;
        e.illegal  = 1'b0;
        case (instr[15:12])
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4: ;
            4'h8, 4'hB, 4'hE: begin
                e.uses_imm = 1'b1;
                e.extend   = 1'b1;
            end
            4'h9, 4'hA, 4'hC, 4'hD: e.uses_imm = 1'b1;
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    state_t state, state_nx;
    entry_t out_q, out_q_nx, skid_q, skid_q_nx;
    logic   out_v, out_v_nx, skid_v, skid_v_nx, in_ready_nx;
    logic   accept, drain;
    entry_t dec;

    assign dec    = decode(in_instr);
    assign accept = in_valid && in_ready && !flush;
    assign drain  = out_v && out_ready;

    // State register and all datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            out_q    <= '0;
            out_v    <= 1'b0;
            skid_q   <= '0;
            skid_v   <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            state    <= state_nx;
            out_q    <= out_q_nx;
            out_v    <= out_v_nx;
            skid_q   <= skid_q_nx;
            skid_v   <= skid_v_nx;
            in_ready <= in_ready_nx;
        end
    end

    // Next-state: flush wins, otherwise refill the output slot from skid before input
    always_comb begin
        state_nx  = state;
        out_q_nx  = out_q;
        out_v_nx  = out_v;
        skid_q_nx = skid_q;
        skid_v_nx = skid_v;

        if (flush) begin
            out_v_nx  = 1'b0;
            skid_v_nx = 1'b0;
            state_nx  = RUN;
        end else begin
            if (drain || !out_v) begin
                if (skid_v) begin
                    out_q_nx  = skid_q;
                    out_v_nx  = 1'b1;
                    skid_v_nx = 1'b0;
                end else if (accept) begin
                    out_q_nx = dec;
                    out_v_nx = 1'b1;
                end else begin
                    out_v_nx = 1'b0;
                end
            end else if (accept) begin
                skid_q_nx = dec;
                skid_v_nx = 1'b1;
            end

            if (accept && dec.illegal) begin
                state_nx = HALT;
            end
        end

        in_ready_nx = !skid_v_nx && (state_nx == RUN);
    end

    assign out_valid    = out_v;
    assign out_opcode   = out_q.instr[15:12];
    assign out_rd       = out_q.instr[11:8];
    assign out_rs       = out_q.instr[7:4];
    assign out_rt       = out_q.instr[3:0];
    assign out_imm8     = out_q.instr[7:0];
    assign out_extend   = out_q.extend;
    assign out_uses_imm = out_q.uses_imm;
    assign out_illegal  = out_q.illegal;
    assign halted       = (state == HALT);

endmodule

// File: tb/tb_decode_stage.sv
// Randomized and directed checking of decode_stage against a queue-based reference model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] in_instr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_opcode, out_rd, out_rs, out_rt;
    logic [7:0]  out_imm8;
    logic        out_extend, out_uses_imm, out_illegal, halted;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_instr(in_instr), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt),
        .out_imm8(out_imm8), .out_extend(out_extend), .out_uses_imm(out_uses_imm),
        .out_illegal(out_illegal), .halted(halted)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model: instructions held by the stage in program order
    logic [15:0] m_q[$];
    logic        m_halted   = 1'b0;
    logic        m_in_ready = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic is_illegal(input logic [15:0] ins);
        return ins[15:12] inside {4'h5, 4'h6, 4'h7, 4'hF};
    endfunction
    function automatic logic uses_imm(input logic [15:0] ins);
        return (int'(ins[15:12]) >= 8) && !is_illegal(ins);
    endfunction
    function automatic logic sign_ext(input logic [15:0] ins);
        return ins[15:12] inside {4'h8, 4'hB, 4'hE};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_halted   = 1'b0;
        m_in_ready = 1'b0;
    endtask

    task automatic compare_all();
        logic [15:0] f;
        check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        check("in_ready", 32'(in_ready), 32'(m_in_ready));
        check("halted", 32'(halted), 32'(m_halted));
        if (m_q.size() > 0) begin
            f = m_q[0];
            check("opcode", 32'(out_opcode), 32'(f[15:12]));
            check("rd", 32'(out_rd), 32'(f[11:8]));
            check("rs", 32'(out_rs), 32'(f[7:4]));
            check("rt", 32'(out_rt), 32'(f[3:0]));
            check("imm8", 32'(out_imm8), 32'(f[7:0]));
            check("extend", 32'(out_extend), 32'(sign_ext(f)));
            check("uses_imm", 32'(out_uses_imm), 32'(uses_imm(f)));
            check("illegal", 32'(out_illegal), 32'(is_illegal(f)));
        end
    endtask

    // One clock: drive at negedge, advance model at posedge, compare at next negedge
    task automatic tick(input logic f, input logic iv, input logic [15:0] ins, input logic ordy);
        logic acc;
        flush     = f;
        in_valid  = iv;
        in_instr  = ins;
        out_ready = ordy;
        @(posedge clk);
        acc = iv && m_in_ready && !f;
        if (f) begin
            m_q.delete();
            m_halted = 1'b0;
        end else begin
            if (m_q.size() > 0 && ordy) void'(m_q.pop_front());
            if (acc) begin
                m_q.push_back(ins);
                if (is_illegal(ins)) m_halted = 1'b1;
            end
        end
        m_in_ready = (m_q.size() < 2) && !m_halted;
        @(negedge clk);
        compare_all();
    endtask

    // Asynchronous reset applied between edges; outputs must clear before any edge
    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst halted", 32'(halted), 32'd0);
        check("rst fields", {out_opcode, out_rd, out_imm8}, 32'd0);
        check("rst flags", {out_extend, out_uses_imm, out_illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        async_reset();
        compare_all();

        // First edge after reset raises in_ready
        tick(0, 0, 16'h0000, 1);
        check("in_ready after reset", 32'(in_ready), 32'd1);

        // ADDI with sign-extended immediate, next-cycle presentation
        tick(0, 1, 16'h8AF3, 1);
        check("addi opcode", 32'(out_opcode), 32'h8);
        check("addi rd", 32'(out_rd), 32'hA);
        check("addi imm8", 32'(out_imm8), 32'hF3);
        check("addi extend", 32'(out_extend), 32'd1);
        check("addi uses_imm", 32'(out_uses_imm), 32'd1);
        tick(0, 0, 16'h0000, 1);

        // Backpressure: skid fills, third is held, all emerge in order
        tick(0, 1, 16'h1123, 0);
        tick(0, 1, 16'h9A80, 0);
        check("skid full in_ready", 32'(in_ready), 32'd0);
        tick(0, 1, 16'hC455, 0);
        check("held front", 32'(out_opcode), 32'h1);
        tick(0, 1, 16'hC455, 1);
        check("second out", 32'(out_opcode), 32'h9);
        tick(0, 1, 16'hC455, 1);
        check("third out", 32'(out_opcode), 32'hC);
        tick(0, 0, 16'h0000, 1);

        // Illegal opcode halts the stage but is still delivered
        tick(0, 1, 16'h7000, 0);
        check("illegal delivered", 32'(out_illegal), 32'd1);
        check("halted", 32'(halted), 32'd1);
        tick(0, 1, 16'h0000, 0);
        tick(0, 1, 16'h0000, 1);
        tick(0, 1, 16'h0000, 1);
        check("halt holds empty", 32'(out_valid), 32'd0);
        tick(1, 1, 16'h0000, 0);
        tick(0, 1, 16'h0000, 1);
        check("nop after flush", 32'(out_valid), 32'd1);
        tick(0, 0, 16'h0000, 1);

        // Flush with skid full and a valid input pending
        tick(0, 1, 16'h1111, 0);
        tick(0, 1, 16'h2222, 0);
        tick(1, 1, 16'h3333, 0);
        check("flush out_valid", 32'(out_valid), 32'd0);
        check("flush in_ready", 32'(in_ready), 32'd1);
        tick(0, 0, 16'h0000, 1);
        check("flush not consumed", 32'(out_valid), 32'd0);

        // Reset mid-stream while output is valid
        tick(0, 1, 16'h4321, 0);
        async_reset();
        compare_all();
        tick(0, 0, 16'h0000, 1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
                compare_all();
            end else begin
                tick(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                     16'($urandom()), ($urandom_range(0, 2) != 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
